// File: rtl/sr_ff_bist.sv
// Self-test sequencer for the SR flip-flop: pulses its reset, walks a fixed set/hold/reset/hold
// sequence, scores q/qbar after a settle delay and keeps a saturating cumulative failure count.
module sr_ff_bist #(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             dut_rst,
   output logic [1:0]       sr_out,
   input  logic             q_in,
   input  logic             qbar_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       fail_vec,
   output logic [CNT_W-1:0] fail_cnt
);

   typedef enum logic [1:0] {IDLE, DRST, STEP, DONE} state_t;

   localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [1:0]       k_q, k_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             dut_rst_q, dut_rst_d;
   logic [1:0]       sr_q, sr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [3:0]       fail_vec_q, fail_vec_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             exp_q;
   logic             step_fail;

   // {S,R} per step; 11 is deliberately absent from the table.
   function automatic logic [1:0] pattern(input logic [1:0] k);
      case (k)
         2'd0:    return 2'b10;
         2'd2:    return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Steps 0/1 expect q=1, steps 2/3 expect q=0; x/z on either input never matches.
   assign exp_q     = ~k_q[1];
   assign step_fail = !((q_in === exp_q) && (qbar_in === ~exp_q));

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      dut_rst_d  = 1'b0;
      sr_d       = 2'b00;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pass_d     = pass_q;
      fail_vec_d = fail_vec_q;
      fail_cnt_d = fail_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = DRST;
               dut_rst_d  = 1'b1;
               busy_d     = 1'b1;
               fail_vec_d = 4'b0000;
               pass_d     = 1'b0;
            end
         end
         DRST: begin
            state_d = STEP;
            k_d     = 2'd0;
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
            sr_d    = pattern(2'd0);
         end
         STEP: begin
            busy_d = 1'b1;
            sr_d   = pattern(k_q);
            if (cnt_q == SETTLE_C) begin
               cnt_d = 4'd0;
               if (step_fail) begin
                  fail_vec_d[k_q] = 1'b1;
                  if (fail_cnt_q != CNT_MAX)
                     fail_cnt_d = fail_cnt_q + 1'b1;
               end
               if (k_q == 2'd3) begin
                  state_d = DONE;
                  k_d     = 2'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  sr_d    = 2'b00;
                  pass_d  = (fail_vec_d == 4'b0000);
               end else begin
                  k_d  = k_q + 2'd1;
                  sr_d = pattern(k_q + 2'd1);
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= 2'd0;
         cnt_q      <= 4'd0;
         dut_rst_q  <= 1'b0;
         sr_q       <= 2'b00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_vec_q <= 4'b0000;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         dut_rst_q  <= dut_rst_d;
         sr_q       <= sr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_vec_q <= fail_vec_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign dut_rst  = dut_rst_q;
   assign sr_out   = sr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign fail_vec = fail_vec_q;
   assign fail_cnt = fail_cnt_q;

endmodule
